// File: rtl/cprv_pkg.sv
// cprv_pkg: shared requester tags and opcode constants for the cprv core
package cprv_pkg;
    typedef enum logic {SRC_IF = 1'b0, SRC_MEM = 1'b1} arb_src_e;
    localparam logic [6:0] LOAD  = 7'b0000011;
    localparam logic [6:0] STORE = 7'b0100011;
endpackage

// File: rtl/cprv_tag_fifo.sv
// cprv_tag_fifo: 1-bit-wide synchronous FIFO remembering which requester owns each in-flight RAM request
module cprv_tag_fifo #(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic                       i_din,
    input  logic                       i_pop,
    output logic                       o_head,
    output logic                       o_empty,
    output logic                       o_full,
    output logic [$clog2(DEPTH):0]     o_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [DEPTH-1:0] r_mem;
    logic [AW-1:0]    r_wp, r_rp;
    logic [CW-1:0]    r_count;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
        end else begin
            if (i_push) r_wp <= r_wp + 1'b1;
            if (i_pop)  r_rp <= r_rp + 1'b1;
            r_count <= r_count + CW'(i_push) - CW'(i_pop);
        end
    end
    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wp] <= i_din;
    end
    assign o_head  = r_mem[r_rp];
    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_count = r_count;
endmodule

// File: rtl/cprv_dmem_arbiter.sv
// cprv_dmem_arbiter: shares one RAM port between IF and the mem stage with in-order response routing.
// Define CPRV_DMEM_ARB_RR_EN for round-robin arbitration instead of fixed MEM > IF priority.
module cprv_dmem_arbiter
    import cprv_pkg::*;
#(
    parameter int DATA_WIDTH      = 64,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_if_i,
    output logic                  ready_if_o,
    input  logic [DATA_WIDTH-1:0] addr_if_i,
    output logic                  valid_if_o,
    input  logic                  ready_if_i,
    output logic [DATA_WIDTH-1:0] rdata_if_o,
    input  logic                  valid_dmem_i,
    output logic                  ready_dmem_o,
    input  logic [DATA_WIDTH-1:0] addr_dmem_i,
    input  logic [DATA_WIDTH-1:0] wdata_dmem_i,
    input  logic                  w_en_dmem_i,
    output logic                  valid_mem_dmem_o,
    input  logic                  ready_mem_dmem_i,
    output logic [DATA_WIDTH-1:0] rdata_dmem_o,
    output logic                  valid_ram_o,
    input  logic                  ready_ram_i,
    output logic [DATA_WIDTH-1:0] addr_ram_o,
    output logic [DATA_WIDTH-1:0] wdata_ram_o,
    output logic                  w_en_ram_o,
    input  logic                  valid_ram_i,
    output logic                  ready_ram_o,
    input  logic [DATA_WIDTH-1:0] rdata_ram_i,
    output logic                  orphan_rsp_o
);
    localparam int CW = $clog2(MAX_OUTSTANDING) + 1;
    logic                  w_cke, w_grant_ok, w_gnt_if, w_gnt_mem, w_push, w_pop;
    logic                  w_head, w_empty, w_full;
    logic [CW-1:0]         w_count;
    arb_src_e              w_head_src;
    logic                  r_valid, r_w_en, r_orphan;
    logic [DATA_WIDTH-1:0] r_addr, r_wdata;
    assign w_cke      = ~r_valid | ready_ram_i;
    // registered count only: a pop this cycle must not free a slot for a push this cycle
    assign w_grant_ok = w_cke & (w_count < CW'(MAX_OUTSTANDING));
`ifdef CPRV_DMEM_ARB_RR_EN
    arb_src_e r_rr;
    assign ready_dmem_o = w_grant_ok & (~valid_if_i | (r_rr == SRC_MEM));
    assign ready_if_o   = w_grant_ok & (~valid_dmem_i | (r_rr == SRC_IF));
    always_ff @(posedge clk) begin
        if (rst)         r_rr <= SRC_MEM;
        else if (w_push) r_rr <= w_gnt_mem ? SRC_IF : SRC_MEM;
    end
`else
    assign ready_dmem_o = w_grant_ok;
    assign ready_if_o   = w_grant_ok & ~valid_dmem_i;
`endif
    assign w_gnt_mem = valid_dmem_i & ready_dmem_o;
    assign w_gnt_if  = valid_if_i & ready_if_o;
    assign w_push    = w_gnt_mem | w_gnt_if;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_w_en  <= 1'b0;
        end else if (w_cke) begin
            r_valid <= w_push;
            if (w_gnt_mem) begin
                r_addr  <= addr_dmem_i;
                r_wdata <= wdata_dmem_i;
                r_w_en  <= w_en_dmem_i;
            end else if (w_gnt_if) begin
                r_addr  <= addr_if_i;
                r_wdata <= '0;
                r_w_en  <= 1'b0;
            end
        end
    end
    assign valid_ram_o = r_valid;
    assign addr_ram_o  = r_addr;
    assign wdata_ram_o = r_wdata;
    assign w_en_ram_o  = r_w_en;
    cprv_tag_fifo #(.DEPTH(MAX_OUTSTANDING)) u_tag_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_din   (w_gnt_mem),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_empty (w_empty),
        .o_full  (w_full),
        .o_count (w_count)
    );
    assign w_head_src       = arb_src_e'(w_head);
    assign valid_if_o       = valid_ram_i & ~w_empty & (w_head_src == SRC_IF);
    assign valid_mem_dmem_o = valid_ram_i & ~w_empty & (w_head_src == SRC_MEM);
    // responses with nobody waiting are swallowed so the RAM never stalls on them
    assign ready_ram_o      = w_empty | ((w_head_src == SRC_MEM) ? ready_mem_dmem_i : ready_if_i);
    assign rdata_if_o       = rdata_ram_i;
    assign rdata_dmem_o     = rdata_ram_i;
    assign w_pop            = valid_ram_i & ready_ram_o & ~w_empty;
    always_ff @(posedge clk) begin
        if (rst) r_orphan <= 1'b0;
        else     r_orphan <= valid_ram_i & w_empty;
    end
    assign orphan_rsp_o = r_orphan;
endmodule

// File: tb/tb_cprv_dmem_arbiter.sv
// tb_cprv_dmem_arbiter: directed self-checking bench for cprv_dmem_arbiter
module tb_cprv_dmem_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        valid_if_i, ready_if_o, valid_if_o, ready_if_i;
    logic [63:0] addr_if_i, rdata_if_o;
    logic        valid_dmem_i, ready_dmem_o, w_en_dmem_i, valid_mem_dmem_o, ready_mem_dmem_i;
    logic [63:0] addr_dmem_i, wdata_dmem_i, rdata_dmem_o;
    logic        valid_ram_o, ready_ram_i, w_en_ram_o, valid_ram_i, ready_ram_o, orphan_rsp_o;
    logic [63:0] addr_ram_o, wdata_ram_o, rdata_ram_i;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    cprv_dmem_arbiter dut (
        .clk(clk), .rst(rst),
        .valid_if_i(valid_if_i), .ready_if_o(ready_if_o), .addr_if_i(addr_if_i),
        .valid_if_o(valid_if_o), .ready_if_i(ready_if_i), .rdata_if_o(rdata_if_o),
        .valid_dmem_i(valid_dmem_i), .ready_dmem_o(ready_dmem_o), .addr_dmem_i(addr_dmem_i),
        .wdata_dmem_i(wdata_dmem_i), .w_en_dmem_i(w_en_dmem_i),
        .valid_mem_dmem_o(valid_mem_dmem_o), .ready_mem_dmem_i(ready_mem_dmem_i),
        .rdata_dmem_o(rdata_dmem_o),
        .valid_ram_o(valid_ram_o), .ready_ram_i(ready_ram_i), .addr_ram_o(addr_ram_o),
        .wdata_ram_o(wdata_ram_o), .w_en_ram_o(w_en_ram_o),
        .valid_ram_i(valid_ram_i), .ready_ram_o(ready_ram_o), .rdata_ram_i(rdata_ram_i),
        .orphan_rsp_o(orphan_rsp_o)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst = 1'b1;
        valid_if_i = 0; addr_if_i = '0; ready_if_i = 0;
        valid_dmem_i = 0; addr_dmem_i = '0; wdata_dmem_i = '0; w_en_dmem_i = 0; ready_mem_dmem_i = 0;
        ready_ram_i = 0; valid_ram_i = 0; rdata_ram_i = '0;
        tick(); tick();
        rst = 1'b0;
        settle();
        check("rst_valid_ram", valid_ram_o, 0);
        check("rst_orphan", orphan_rsp_o, 0);
        check("rst_addr", addr_ram_o, 0);
        check("rst_wdata", wdata_ram_o, 0);
        check("rst_wen", w_en_ram_o, 0);
        check("rst_ready_dmem", ready_dmem_o, 1);
        check("rst_ready_if", ready_if_o, 1);
        check("rst_ready_ram", ready_ram_o, 1);

`ifdef CPRV_DMEM_ARB_RR_EN
        ready_ram_i = 1; ready_if_i = 1; ready_mem_dmem_i = 1;
        valid_if_i = 1; addr_if_i = 64'h1000;
        valid_dmem_i = 1; addr_dmem_i = 64'h2000;
        for (int i = 0; i < 4; i++) begin
            settle();
            check("rr_ready_dmem", ready_dmem_o, (i % 2 == 0) ? 1 : 0);
            check("rr_ready_if", ready_if_o, (i % 2 == 0) ? 0 : 1);
            tick();
            valid_ram_i = 1;
            check("rr_grant_addr", addr_ram_o, (i % 2 == 0) ? 64'h2000 : 64'h1000);
        end
        valid_if_i = 0; valid_dmem_i = 0; valid_ram_i = 0;
`else
        // MEM beats IF, then IF follows; responses route in order
        ready_ram_i = 1;
        valid_if_i = 1; addr_if_i = 64'h1000;
        valid_dmem_i = 1; addr_dmem_i = 64'h2000; w_en_dmem_i = 0;
        settle();
        check("prio_ready_dmem", ready_dmem_o, 1);
        check("prio_ready_if", ready_if_o, 0);
        tick();
        check("prio_n1_valid", valid_ram_o, 1);
        check("prio_n1_addr", addr_ram_o, 64'h2000);
        valid_dmem_i = 0;
        settle();
        check("prio_if_ready", ready_if_o, 1);
        tick();
        check("prio_n2_addr", addr_ram_o, 64'h1000);
        check("prio_n2_wen", w_en_ram_o, 0);
        check("prio_n2_wdata", wdata_ram_o, 0);
        valid_if_i = 0;
        tick();
        check("prio_idle_valid", valid_ram_o, 0);
        ready_if_i = 1; ready_mem_dmem_i = 1;
        valid_ram_i = 1; rdata_ram_i = 64'hAA;
        settle();
        check("rsp1_mem_valid", valid_mem_dmem_o, 1);
        check("rsp1_if_valid", valid_if_o, 0);
        check("rsp1_rdata", rdata_dmem_o, 64'hAA);
        tick();
        rdata_ram_i = 64'hBB;
        settle();
        check("rsp2_if_valid", valid_if_o, 1);
        check("rsp2_mem_valid", valid_mem_dmem_o, 0);
        check("rsp2_rdata", rdata_if_o, 64'hBB);
        tick();
        valid_ram_i = 0;

        // RAM back-pressure holds the request slice
        ready_ram_i = 0;
        valid_dmem_i = 1; addr_dmem_i = 64'h3000; wdata_dmem_i = 64'h55; w_en_dmem_i = 1;
        settle();
        check("stall_first_ready", ready_dmem_o, 1);
        tick();
        addr_dmem_i = 64'h4000; wdata_dmem_i = 64'h0; w_en_dmem_i = 0;
        for (int i = 0; i < 3; i++) begin
            settle();
            check("stall_ready_dmem", ready_dmem_o, 0);
            check("stall_ready_if", ready_if_o, 0);
            check("stall_valid", valid_ram_o, 1);
            check("stall_addr", addr_ram_o, 64'h3000);
            check("stall_wdata", wdata_ram_o, 64'h55);
            check("stall_wen", w_en_ram_o, 1);
            tick();
        end
        ready_ram_i = 1;
        settle();
        check("stall_release_ready", ready_dmem_o, 1);
        tick();
        check("stall_next_addr", addr_ram_o, 64'h4000);
        valid_dmem_i = 0;
        tick();
        valid_ram_i = 1;
        for (int i = 0; i < 2; i++) begin
            settle();
            check("stall_drain_valid", valid_mem_dmem_o, 1);
            tick();
        end
        valid_ram_i = 0;

        // outstanding limit: third store waits for a pop
        w_en_dmem_i = 1; valid_dmem_i = 1;
        addr_dmem_i = 64'h5000; wdata_dmem_i = 64'h1;
        settle();
        check("full_a_ready", ready_dmem_o, 1);
        tick();
        addr_dmem_i = 64'h5008; wdata_dmem_i = 64'h2;
        settle();
        check("full_b_ready", ready_dmem_o, 1);
        tick();
        addr_dmem_i = 64'h5010; wdata_dmem_i = 64'h3;
        settle();
        check("full_c_blocked", ready_dmem_o, 0);
        check("full_b_addr", addr_ram_o, 64'h5008);
        tick();
        check("full_c_blocked2", ready_dmem_o, 0);
        check("full_idle_valid", valid_ram_o, 0);
        valid_ram_i = 1;
        settle();
        check("full_pop_ready_ram", ready_ram_o, 1);
        check("full_pop_same_cycle", ready_dmem_o, 0);
        tick();
        valid_ram_i = 0;
        settle();
        check("full_after_pop_ready", ready_dmem_o, 1);
        tick();
        check("full_c_addr", addr_ram_o, 64'h5010);
        check("full_c_wdata", wdata_ram_o, 64'h3);
        valid_dmem_i = 0; w_en_dmem_i = 0; wdata_dmem_i = 0;
        valid_ram_i = 1;
        tick(); tick();
        valid_ram_i = 0;

        // head-of-line: stalled MEM response blocks an IF response behind it
        valid_dmem_i = 1; addr_dmem_i = 64'h6000;
        valid_if_i = 1; addr_if_i = 64'h7000;
        tick();
        valid_dmem_i = 0;
        settle();
        check("hol_if_ready", ready_if_o, 1);
        tick();
        valid_if_i = 0;
        ready_mem_dmem_i = 0; ready_if_i = 1;
        valid_ram_i = 1; rdata_ram_i = 64'hCC;
        for (int i = 0; i < 2; i++) begin
            settle();
            check("hol_ready_ram", ready_ram_o, 0);
            check("hol_mem_valid", valid_mem_dmem_o, 1);
            check("hol_if_blocked", valid_if_o, 0);
            tick();
        end
        ready_mem_dmem_i = 1;
        settle();
        check("hol_release", ready_ram_o, 1);
        tick();
        settle();
        check("hol_if_now", valid_if_o, 1);
        check("hol_mem_now", valid_mem_dmem_o, 0);
        valid_ram_i = 0;
        valid_dmem_i = 1; addr_dmem_i = 64'h8000;
        tick();
        valid_dmem_i = 0;

        // reset with two in flight; late response becomes an orphan
        rst = 1;
        tick();
        rst = 0;
        settle();
        check("rr_rst_valid", valid_ram_o, 0);
        check("rr_rst_orphan", orphan_rsp_o, 0);
        ready_if_i = 0; ready_mem_dmem_i = 0;
        valid_ram_i = 1;
        settle();
        check("orph_ready_ram", ready_ram_o, 1);
        check("orph_if_valid", valid_if_o, 0);
        check("orph_mem_valid", valid_mem_dmem_o, 0);
        tick();
        valid_ram_i = 0;
        check("orph_pulse", orphan_rsp_o, 1);
        tick();
        check("orph_pulse_end", orphan_rsp_o, 0);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
